// File: rtl/router_input_port.sv
// Per-input-port router front end: flit FIFO, XY route computation on head
// flits, and a wormhole FSM that holds one output-port request per packet.
module router_input_port #(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [4:0]        req,
  input  logic              gnt,
  output logic [FLIT_W-1:0] out_flit,
  output logic [2:0]        route,
  output logic              err_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [COORD_W-1:0] X_C = X_COORD[COORD_W-1:0];
  localparam logic [COORD_W-1:0] Y_C = Y_COORD[COORD_W-1:0];

  localparam logic IDLE   = 1'b0;
  localparam logic ACTIVE = 1'b1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;

  localparam logic [1:0] T_HEAD   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               state_q;
  logic [2:0]         route_q;

  logic               empty, push, pop;
  logic               is_head, lock, drop, fwd, last;
  logic [1:0]         head_type;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic [2:0]         calc_route;

  // Upstream handshake: a flit transfers on a cycle where in_valid && in_ready;
  // in_ready depends only on the registered count.
  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign empty    = (count_q == '0);
  assign out_flit = mem[rd_ptr_q];

  assign head_type = out_flit[FLIT_W-1 -: 2];
  assign dest_x    = out_flit[FLIT_W-3 -: COORD_W];
  assign dest_y    = out_flit[FLIT_W-3-COORD_W -: COORD_W];

  // X dimension is resolved before Y, which keeps XY routing deadlock-free.
  always_comb begin
    calc_route = P_LOCAL;
    if (dest_x > X_C)      calc_route = P_EAST;
    else if (dest_x < X_C) calc_route = P_WEST;
    else if (dest_y > Y_C) calc_route = P_NORTH;
    else if (dest_y < Y_C) calc_route = P_SOUTH;
  end

  assign is_head = (head_type == T_HEAD) || (head_type == T_SINGLE);
  assign lock    = (state_q == IDLE) && !empty && is_head;
  assign drop    = (state_q == IDLE) && !empty && !is_head;
  assign fwd     = (state_q == ACTIVE) && !empty && gnt;
  assign last    = fwd && ((head_type == T_TAIL) || (head_type == T_SINGLE));
  assign pop     = drop || fwd;

  assign req      = ((state_q == ACTIVE) && !empty) ? (5'b00001 << route_q) : 5'b00000;
  assign route    = route_q;
  assign err_drop = drop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_flit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Route stays locked while starved mid-packet; only the tail releases it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= P_LOCAL;
    end else begin
      case (state_q)
        IDLE: begin
          if (lock) begin
            route_q <= calc_route;
            state_q <= ACTIVE;
          end
        end
        default: begin
          if (last) state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
